// File: rtl/cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Brief    : Per-producer result FIFOs feeding a multi-lane common data bus.
//            Up to CDB_W FIFO heads are granted each cycle with round-robin
//            priority. Lanes are packed from lane 0.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
    parameter int NUM_SRC    = 6,
    parameter int CDB_W      = 4,
    parameter int TAG_W      = 6,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [NUM_SRC-1:0]  src_valid_i,
    output logic [NUM_SRC-1:0]  src_ready_o,
    input  logic [TAG_W-1:0]    src_tag_i [0:NUM_SRC-1],
    input  logic [DATA_W-1:0]   src_val_i [0:NUM_SRC-1],
    output logic [CDB_W-1:0]    cdb_valid_o,
    output logic [TAG_W-1:0]    cdb_tag_o [0:CDB_W-1],
    output logic [DATA_W-1:0]   cdb_val_o [0:CDB_W-1]
);

    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);
    localparam int c_rr_w  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam logic [c_cnt_w-1:0] c_full = c_cnt_w'(FIFO_DEPTH);

    // FIFO control state (reset) and storage (not reset)
    logic [c_cnt_w-1:0] count_q  [NUM_SRC];
    logic [c_cnt_w-1:0] count_d  [NUM_SRC];
    logic [c_ptr_w-1:0] rd_ptr_q [NUM_SRC];
    logic [c_ptr_w-1:0] rd_ptr_d [NUM_SRC];
    logic [c_ptr_w-1:0] wr_ptr_q [NUM_SRC];
    logic [c_ptr_w-1:0] wr_ptr_d [NUM_SRC];
    logic [c_rr_w-1:0]  rr_ptr_q;
    logic [c_rr_w-1:0]  rr_ptr_d;
    logic [TAG_W-1:0]   tag_mem_q [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0]  val_mem_q [NUM_SRC][FIFO_DEPTH];

    logic [NUM_SRC-1:0] w_push;
    logic [NUM_SRC-1:0] w_grant;
    logic [NUM_SRC-1:0] w_nonempty;
    int                 w_off  [NUM_SRC];
    int                 w_rank [NUM_SRC];
    int                 w_best_off;
    int                 w_last;

    // Ready is a function of the registered count only, so a same-cycle pop
    // never frees the slot for a push.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            src_ready_o[s] = (count_q[s] < c_full) && !flush_i;
            w_push[s]      = src_valid_i[s] && src_ready_o[s];
            w_nonempty[s]  = (count_q[s] != '0);
        end
    end

    // Rotated-priority grant: a source's lane is the number of non-empty
    // sources that sit ahead of it in the scan starting at rr_ptr.
    always_comb begin
        w_grant     = '0;
        w_best_off  = -1;
        w_last      = 0;
        cdb_valid_o = '0;
        for (int l = 0; l < CDB_W; l++) begin
            cdb_tag_o[l] = '0;
            cdb_val_o[l] = '0;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            w_off[s]  = (s - int'(rr_ptr_q) + NUM_SRC) % NUM_SRC;
            w_rank[s] = 0;
        end
        for (int s = 0; s < NUM_SRC; s++) begin
            for (int t = 0; t < NUM_SRC; t++) begin
                if (w_nonempty[t] && (w_off[t] < w_off[s])) begin
                    w_rank[s] = w_rank[s] + 1;
                end
            end
            w_grant[s] = w_nonempty[s] && (w_rank[s] < CDB_W) && !flush_i;
            if (w_grant[s] && (w_off[s] > w_best_off)) begin
                w_best_off = w_off[s];
                w_last     = s;
            end
        end
        for (int l = 0; l < CDB_W; l++) begin
            for (int s = 0; s < NUM_SRC; s++) begin
                if (w_grant[s] && (w_rank[s] == l)) begin
                    cdb_valid_o[l] = 1'b1;
                    cdb_tag_o[l]   = tag_mem_q[s][rd_ptr_q[s]];
                    cdb_val_o[l]   = val_mem_q[s][rd_ptr_q[s]];
                end
            end
        end
        rr_ptr_d = (w_grant != '0) ? c_rr_w'((w_last + 1) % NUM_SRC) : rr_ptr_q;
    end

    // Next-state for counts and pointers; flush empties every FIFO.
    always_comb begin
        for (int s = 0; s < NUM_SRC; s++) begin
            count_d[s]  = count_q[s];
            rd_ptr_d[s] = rd_ptr_q[s];
            wr_ptr_d[s] = wr_ptr_q[s];
            case ({w_push[s], w_grant[s]})
                2'b10:   count_d[s] = count_q[s] + c_cnt_w'(1);
                2'b01:   count_d[s] = count_q[s] - c_cnt_w'(1);
                default: count_d[s] = count_q[s];
            endcase
            if (w_grant[s]) rd_ptr_d[s] = rd_ptr_q[s] + c_ptr_w'(1);
            if (w_push[s])  wr_ptr_d[s] = wr_ptr_q[s] + c_ptr_w'(1);
            if (flush_i) begin
                count_d[s]  = '0;
                rd_ptr_d[s] = '0;
                wr_ptr_d[s] = '0;
            end
        end
    end

    // Control state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
            for (int s = 0; s < NUM_SRC; s++) begin
                count_q[s]  <= '0;
                rd_ptr_q[s] <= '0;
                wr_ptr_q[s] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int s = 0; s < NUM_SRC; s++) begin
                count_q[s]  <= count_d[s];
                rd_ptr_q[s] <= rd_ptr_d[s];
                wr_ptr_q[s] <= wr_ptr_d[s];
            end
        end
    end

    // FIFO payload write on accepted push.
    always_ff @(posedge clk) begin
        for (int s = 0; s < NUM_SRC; s++) begin
            if (w_push[s]) begin
                tag_mem_q[s][wr_ptr_q[s]] <= src_tag_i[s];
                val_mem_q[s][wr_ptr_q[s]] <= src_val_i[s];
            end
        end
    end

    // Producers must never present a result to a full FIFO.
    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src_chk
        a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
            !(src_valid_i[s] && (count_q[s] == c_full)));
    end

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Brief    : Directed self-checking bench for cdb_arbiter (6 sources,
//            4 lanes, depth 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush_i;
    logic [5:0]  src_valid_i;
    logic [5:0]  src_ready_o;
    logic [5:0]  src_tag_i [0:5];
    logic [31:0] src_val_i [0:5];
    logic [3:0]  cdb_valid_o;
    logic [5:0]  cdb_tag_o [0:3];
    logic [31:0] cdb_val_o [0:3];

    int n_tests = 0;
    int n_fail  = 0;

    cdb_arbiter #(
        .NUM_SRC    (6),
        .CDB_W      (4),
        .TAG_W      (6),
        .DATA_W     (32),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .src_valid_i (src_valid_i),
        .src_ready_o (src_ready_o),
        .src_tag_i   (src_tag_i),
        .src_val_i   (src_val_i),
        .cdb_valid_o (cdb_valid_o),
        .cdb_tag_o   (cdb_tag_o),
        .cdb_val_o   (cdb_val_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Randomly-free directed backpressure run against a small queue model.
    task automatic run_backpressure();
        logic [5:0] mbuf [6][2];
        int         mcnt [6];
        int         gsrc [4];
        logic [5:0] etag [4];
        logic [3:0] emask;
        logic [5:0] erdy;
        logic [5:0] t;
        int mrr, n, s, hs, bc;
        bit drop, done;
        mrr = 0; hs = 0; bc = 0; drop = 0; done = 0;
        for (int i = 0; i < 6; i++) mcnt[i] = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            n = 0;
            emask = '0;
            for (int k = 0; k < 6; k++) begin
                s = (mrr + k) % 6;
                if (mcnt[s] > 0 && n < 4) begin
                    etag[n]  = mbuf[s][0];
                    gsrc[n]  = s;
                    emask[n] = 1'b1;
                    n++;
                end
            end
            for (int i = 0; i < 6; i++) erdy[i] = (mcnt[i] < 2);
            chk("bp_valid", cdb_valid_o, emask);
            for (int l = 0; l < n; l++) begin
                chk("bp_tag", cdb_tag_o[l], etag[l]);
                chk("bp_val", cdb_val_o[l], 32'hA000_0000 | 32'(etag[l]));
            end
            chk("bp_ready", src_ready_o, erdy);
            for (int l = 0; l < 4; l++) if (cdb_valid_o[l]) bc++;
            if (src_ready_o != 6'h3F) drop = 1;
            for (int l = 0; l < n; l++) begin
                mbuf[gsrc[l]][0] = mbuf[gsrc[l]][1];
                mcnt[gsrc[l]]--;
            end
            if (n > 0) mrr = (gsrc[n-1] + 1) % 6;
            if (cyc >= 8 && n == 0) begin
                done = 1;
                break;
            end
            for (int i = 0; i < 6; i++) begin
                t = 6'(i * 8 + (cyc % 8));
                src_tag_i[i]   = t;
                src_val_i[i]   = 32'hA000_0000 | 32'(t);
                src_valid_i[i] = (cyc < 8) && erdy[i];
                if (src_valid_i[i]) begin
                    mbuf[i][mcnt[i]] = t;
                    mcnt[i]++;
                    hs++;
                end
            end
            tick();
        end
        src_valid_i = '0;
        chk("bp_done", done, 1);
        chk("bp_drop", drop, 1);
        chk("bp_count", bc, hs);
    endtask

    initial begin
        rst_n = 1'b1;
        flush_i = 1'b0;
        src_valid_i = '0;
        for (int i = 0; i < 6; i++) begin
            src_tag_i[i] = '0;
            src_val_i[i] = '0;
        end

        // Reset asserted mid-cycle takes effect immediately
        #3 rst_n = 1'b0;
        #1;
        chk("rst_valid", cdb_valid_o, 4'b0000);
        chk("rst_ready", src_ready_o, 6'h3F);
        chk("rst_rr", dut.rr_ptr_q, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_valid0", cdb_valid_o, 4'b0000);
        tick();
        chk("post_rst_valid1", cdb_valid_o, 4'b0000);

        // Single result from src2
        src_tag_i[2] = 6'd5; src_val_i[2] = 32'hDEAD; src_valid_i = 6'b000100;
        tick();
        src_valid_i = '0;
        chk("single_valid", cdb_valid_o, 4'b0001);
        chk("single_tag", cdb_tag_o[0], 6'd5);
        chk("single_val", cdb_val_o[0], 32'hDEAD);
        tick();
        chk("single_rr", dut.rr_ptr_q, 3);
        chk("single_after", cdb_valid_o, 4'b0000);

        // Bring rr_ptr back to 0 via src5
        src_tag_i[5] = 6'd1; src_valid_i = 6'b100000;
        tick();
        src_valid_i = '0;
        chk("src5_valid", cdb_valid_o, 4'b0001);
        tick();
        chk("src5_rr", dut.rr_ptr_q, 0);

        // Contention: all six push tags 10..15
        for (int i = 0; i < 6; i++) begin
            src_tag_i[i] = 6'(10 + i);
            src_val_i[i] = 32'(256 + i);
        end
        src_valid_i = 6'h3F;
        tick();
        src_valid_i = '0;
        chk("cont1_valid", cdb_valid_o, 4'b1111);
        for (int l = 0; l < 4; l++) chk("cont1_tag", cdb_tag_o[l], 6'(10 + l));
        tick();
        chk("cont2_rr", dut.rr_ptr_q, 4);
        chk("cont2_valid", cdb_valid_o, 4'b0011);
        chk("cont2_tag0", cdb_tag_o[0], 6'd14);
        chk("cont2_tag1", cdb_tag_o[1], 6'd15);
        chk("cont2_val1", cdb_val_o[1], 32'd261);
        chk("cont2_tag2_zero", cdb_tag_o[2], 6'd0);
        chk("cont2_val3_zero", cdb_val_o[3], 32'd0);
        tick();
        chk("cont3_rr", dut.rr_ptr_q, 0);
        chk("cont3_valid", cdb_valid_o, 4'b0000);

        // Move rr_ptr to 1, then load src0 with 2 entries and src4 with 1
        src_tag_i[0] = 6'd9; src_valid_i = 6'b000001;
        tick();
        src_valid_i = '0;
        chk("pre_fl_tag", cdb_tag_o[0], 6'd9);
        tick();
        chk("pre_fl_rr", dut.rr_ptr_q, 1);
        src_tag_i[0] = 6'd20; src_tag_i[1] = 6'd30; src_tag_i[2] = 6'd31;
        src_tag_i[3] = 6'd32; src_tag_i[5] = 6'd33;
        src_valid_i = 6'b101111;
        tick();
        chk("fl_load_valid", cdb_valid_o, 4'b1111);
        chk("fl_load_tag0", cdb_tag_o[0], 6'd30);
        chk("fl_load_tag3", cdb_tag_o[3], 6'd33);
        src_tag_i[0] = 6'd22; src_tag_i[4] = 6'd21;
        src_valid_i = 6'b010001;
        tick();
        src_valid_i = '0;
        flush_i = 1'b1;
        #1;
        chk("fl_valid", cdb_valid_o, 4'b0000);
        chk("fl_ready", src_ready_o, 6'h00);
        tick();
        flush_i = 1'b0;
        #1;
        chk("fl_after_valid", cdb_valid_o, 4'b0000);
        chk("fl_after_ready", src_ready_o, 6'h3F);
        chk("fl_after_rr", dut.rr_ptr_q, 0);
        tick();
        chk("fl_after2_valid", cdb_valid_o, 4'b0000);

        // Backpressure with all producers active for 8 cycles
        run_backpressure();

        // Move rr_ptr to 2 via src1
        src_tag_i[1] = 6'd7; src_valid_i = 6'b000010;
        tick();
        src_valid_i = '0;
        chk("pre_fp_tag", cdb_tag_o[0], 6'd7);
        tick();
        chk("pre_fp_rr", dut.rr_ptr_q, 2);

        // Fill src1 (A, B) while sources 2..5 take all lanes
        src_tag_i[1] = 6'h2A;
        for (int i = 2; i < 6; i++) src_tag_i[i] = 6'(40 + i - 2);
        src_valid_i = 6'b111110;
        tick();
        chk("fp_load_valid", cdb_valid_o, 4'b1111);
        chk("fp_load_tag0", cdb_tag_o[0], 6'd40);
        src_tag_i[1] = 6'h2B; src_valid_i = 6'b000010;
        tick();
        src_valid_i = '0;
        chk("fp1_valid", cdb_valid_o, 4'b0001);
        chk("fp1_tag", cdb_tag_o[0], 6'h2A);
        chk("fp1_ready", src_ready_o, 6'b111101);
        tick();
        chk("fp2_ready", src_ready_o[1], 1'b1);
        chk("fp2_tag", cdb_tag_o[0], 6'h2B);
        src_tag_i[1] = 6'h2C; src_valid_i = 6'b000010;
        tick();
        src_valid_i = '0;
        chk("fp3_valid", cdb_valid_o, 4'b0001);
        chk("fp3_tag", cdb_tag_o[0], 6'h2C);
        tick();
        chk("fp4_valid", cdb_valid_o, 4'b0000);

        // Reset mid-transfer clears pending entries at once
        src_tag_i[3] = 6'd3; src_valid_i = 6'b001000;
        tick();
        src_valid_i = '0;
        chk("rst2_pre_valid", cdb_valid_o, 4'b0001);
        #2 rst_n = 1'b0;
        #1;
        chk("rst2_valid", cdb_valid_o, 4'b0000);
        chk("rst2_ready", src_ready_o, 6'h3F);
        chk("rst2_rr", dut.rr_ptr_q, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rst2_after_valid", cdb_valid_o, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
